// File: rtl/l1_wb_req_tx.sv
// L1-side WB_REQ transmitter: queues dirty evictions and sends one msg3 beat per line, with tag snoop.
// Optional feature macro: WB_CLEAN_NOTIFY_EN (clean evictions also sent, as type 8'h0D with zero data).
module l1_wb_req_tx #(
  parameter int         DEPTH  = 2,
  parameter logic [5:0] SRC_ID = 6'd0,
  parameter int         TAG_W  = 26,
  parameter int         DATA_W = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          evict_valid,
  output logic                          evict_ready,
  input  logic                          evict_dirty,
  input  logic [TAG_W-1:0]              evict_tag,
  input  logic [DATA_W-1:0]             evict_data,
  output logic                          msg3_valid,
  input  logic                          msg3_ready,
  output logic [7:0]                    msg3_type,
  output logic [5:0]                    msg3_source,
  output logic [TAG_W-1:0]              msg3_tag,
  output logic [DATA_W-1:0]             msg3_data,
  input  logic [TAG_W-1:0]              snoop_tag,
  output logic                          snoop_hit,
  output logic [$clog2(DEPTH+2)-1:0]    occupancy
);

  localparam int             PTR_W      = $clog2(DEPTH);
  localparam int             OCC_W      = $clog2(DEPTH+2);
  localparam logic [7:0]     TYPE_WB    = 8'h0C;
  localparam logic [PTR_W:0] PTR_ONE    = {{PTR_W{1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [TAG_W-1:0]    tag_mem_r  [DEPTH];
  logic [DATA_W-1:0]   data_mem_r [DEPTH];
`ifdef WB_CLEAN_NOTIFY_EN
  localparam logic [7:0] TYPE_CLEAN = 8'h0D;
  logic                clean_mem_r [DEPTH];
`endif
  logic [PTR_W:0]      wr_ptr_r;
  logic [PTR_W:0]      rd_ptr_r;
  logic [PTR_W:0]      count_s;
  logic [PTR_W-1:0]    rd_idx_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic                push_s;
  logic                load_s;
  logic                snoop_hit_s;
  logic [PTR_W-1:0]    off_s;
  logic [7:0]          type_r;
  logic [TAG_W-1:0]    tag_r;
  logic [DATA_W-1:0]   data_r;

  // The extra wrap bit separates full from empty when the index bits match.
  assign count_s      = wr_ptr_r - rd_ptr_r;
  assign rd_idx_s     = rd_ptr_r[PTR_W-1:0];
  assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
  assign fifo_full_s  = (wr_ptr_r[PTR_W] != rd_ptr_r[PTR_W]) &&
                        (wr_ptr_r[PTR_W-1:0] == rd_ptr_r[PTR_W-1:0]);
  assign evict_ready  = !fifo_full_s;

`ifdef WB_CLEAN_NOTIFY_EN
  assign push_s = evict_valid && !fifo_full_s;
`else
  assign push_s = evict_valid && !fifo_full_s && evict_dirty;
`endif

  assign msg3_valid  = (state_r == SEND);
  assign msg3_type   = type_r;
  assign msg3_source = SRC_ID;
  assign msg3_tag    = tag_r;
  assign msg3_data   = data_r;
  assign snoop_hit   = snoop_hit_s;
  assign occupancy   = OCC_W'(count_s) + OCC_W'(state_r == SEND);

  // Output FSM next-state: load the head whenever the output register is free or being accepted.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          load_s  = 1'b1;
          state_s = SEND;
        end else begin
          state_s = IDLE;
        end
      end
      SEND: begin
        if (msg3_ready) begin
          if (!fifo_empty_s) begin
            load_s  = 1'b1;
            state_s = SEND;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = SEND;
        end
      end
      default: begin
        load_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // FSM state and FIFO pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      wr_ptr_r <= {(PTR_W+1){1'b0}};
      rd_ptr_r <= {(PTR_W+1){1'b0}};
    end else begin
      state_r <= state_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (load_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // FIFO storage; contents are only meaningful between the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      tag_mem_r[wr_ptr_r[PTR_W-1:0]] <= evict_tag;
`ifdef WB_CLEAN_NOTIFY_EN
      clean_mem_r[wr_ptr_r[PTR_W-1:0]] <= !evict_dirty;
      data_mem_r[wr_ptr_r[PTR_W-1:0]]  <= evict_dirty ? evict_data : {DATA_W{1'b0}};
`else
      data_mem_r[wr_ptr_r[PTR_W-1:0]]  <= evict_data;
`endif
    end
  end

  // Output register: payload changes only on a load, so it is stable while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      type_r <= 8'h00;
      tag_r  <= {TAG_W{1'b0}};
      data_r <= {DATA_W{1'b0}};
    end else if (load_s) begin
`ifdef WB_CLEAN_NOTIFY_EN
      type_r <= clean_mem_r[rd_idx_s] ? TYPE_CLEAN : TYPE_WB;
`else
      type_r <= TYPE_WB;
`endif
      tag_r  <= tag_mem_r[rd_idx_s];
      data_r <= data_mem_r[rd_idx_s];
    end
  end

  // Snoop: entry i is live when its distance from the read pointer is below the fill count.
  always_comb begin
    snoop_hit_s = 1'b0;
    off_s       = {PTR_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      off_s = PTR_W'(i) - rd_idx_s;
      if (({1'b0, off_s} < count_s) && (tag_mem_r[i] == snoop_tag)) begin
        snoop_hit_s = 1'b1;
      end else begin
        snoop_hit_s = snoop_hit_s;
      end
    end
    if ((state_r == SEND) && (tag_r == snoop_tag)) begin
      snoop_hit_s = 1'b1;
    end else begin
      snoop_hit_s = snoop_hit_s;
    end
  end

endmodule
